// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared definitions for the multiply/divide unit.
//   Operation encodings (also imported by the decoder and the hazard unit),
//   controller state enum, default latencies, and the multi-cycle classifier.
//   Optional feature macro: MDU_MADD_EN (MADD/MSUB decoded as accumulate ops).
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MADD  = 3'd6,
        MDU_MSUB  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

    // True for operations that occupy the unit for more than one cycle.
    // Without MDU_MADD_EN, MADD/MSUB are no-ops and therefore single-cycle.
    function automatic logic mdu_is_multi(input logic [2:0] op);
        case (mdu_op_e'(op))
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MSUB:                     return 1'b1;
`endif
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic mdu_is_div(input logic [2:0] op);
        return (mdu_op_e'(op) == MDU_DIV) || (mdu_op_e'(op) == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith -- combinational datapath of the multiply/divide unit.
//   Computes the 64-bit {HI,LO} result for the issued op; the controller
//   registers it and commits it after the op latency.
//   Optional feature macro: MDU_MADD_EN (enables the MADD/MSUB accumulator).
// Ports:
//   op       in  3   operation encoding (mdu_op_e)
//   a, b     in  32  rs / rt operands
//   hi, lo   in  32  accumulator base for MADD/MSUB
//   res      out 64  {HI,LO} result (HI=remainder, LO=quotient for divides)
//   div_zero out 1   divide op with b==0; commit must be suppressed
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic               b_zero;

    assign b_zero = (b == '0);
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Divider inputs are gated on b==0 so no divide-by-zero is ever evaluated;
    // the result is discarded in that case anyway.
    always_comb begin
        quot_s = '0;
        rem_s  = '0;
        quot_u = '0;
        rem_u  = '0;
        if (!b_zero) begin
            quot_s = $signed(a) / $signed(b);
            rem_s  = $signed(a) % $signed(b);
            quot_u = a / b;
            rem_u  = a % b;
        end
    end

    always_comb begin
        res      = '0;
        div_zero = b_zero && mdu_is_div(op);
        case (mdu_op_e'(op))
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV:   res = {rem_s, quot_s};
            MDU_DIVU:  res = {rem_u, quot_u};
`ifdef MDU_MADD_EN
            MDU_MADD:  res = {hi, lo} + prod_s;
            MDU_MSUB:  res = {hi, lo} - prod_s;
`else
            // Pass-through only; the controller never commits these.
            MDU_MADD, MDU_MSUB: res = {hi, lo};
`endif
            default:   res = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multiply/divide unit controller.
//   Accepts HI/LO-class ops from the E stage, sequences multi-cycle ops with a
//   down-counter, owns the HI/LO registers, and raises a D-stage stall while a
//   D-stage HI/LO user would observe an unfinished result.
//   Optional feature macro: MDU_MADD_EN (MADD/MSUB accumulate into HI/LO).
// Ports:
//   clk, reset   in  1   clock; asynchronous active-high reset
//   start        in  1   E-stage issue (already qualified by "not stalled")
//   op           in  3   operation encoding (mdu_op_e)
//   a, b         in  32  rs / rt operands after forwarding
//   cancel       in  1   same-cycle flush; suppresses start
//   d_uses_md    in  1   D-stage instruction touches the MDU
//   busy         out 1   multi-cycle op in flight
//   stall        out 1   freeze F/D, bubble E
//   hi, lo       out 32  architectural HI / LO
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        d_uses_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e  state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [63:0] res, res_next;
    logic        dz, dz_next;
    logic [31:0] hi_next, lo_next;

    logic        go;
    logic        multi;
    logic        finishing;
    logic [63:0] acc_base;
    logic [63:0] arith_res;
    logic        arith_dz;

    assign go        = start && !cancel;
    assign multi     = mdu_is_multi(op);
    assign finishing = (state == MDU_RUN) && (cnt == '0);

    // An op accepted on the completion edge must accumulate onto the value
    // being committed on that same edge, not the stale HI/LO.
    assign acc_base = (finishing && !dz) ? res : {hi, lo};

    mdu_arith u_arith (
        .op       (op),
        .a        (a),
        .b        (b),
        .hi       (acc_base[63:32]),
        .lo       (acc_base[31:0]),
        .res      (arith_res),
        .div_zero (arith_dz)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MDU_IDLE;
            cnt   <= '0;
            res   <= '0;
            dz    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            res   <= res_next;
            dz    <= dz_next;
            hi    <= hi_next;
            lo    <= lo_next;
        end
    end

    always_comb begin
        logic accept;
        state_next = state;
        cnt_next   = cnt;
        res_next   = res;
        dz_next    = dz;
        hi_next    = hi;
        lo_next    = lo;
        accept     = 1'b0;

        case (state)
            MDU_IDLE: accept = go;
            MDU_RUN: begin
                if (cnt == '0) begin
                    state_next = MDU_IDLE;
                    if (!dz) begin
                        hi_next = res[63:32];
                        lo_next = res[31:0];
                    end
                    accept = go;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: state_next = MDU_IDLE;
        endcase

        // Issue is applied after the completion commit so a later MTHI/MTLO
        // overrides the finishing result, matching program order.
        if (accept) begin
            case (mdu_op_e'(op))
                MDU_MTHI: hi_next = a;
                MDU_MTLO: lo_next = a;
                default: begin
                    if (multi) begin
                        res_next   = arith_res;
                        dz_next    = arith_dz;
                        state_next = MDU_RUN;
                        cnt_next   = mdu_is_div(op) ? 4'(DIV_CYCLES - 1)
                                                    : 4'(MULT_CYCLES - 1);
                    end
                end
            endcase
        end
    end

    assign busy  = (state == MDU_RUN);
    assign stall = d_uses_md && (busy || (go && multi));

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        d_uses_md = 1'b0;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;
    int go_in_run = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .cancel    (cancel),
        .d_uses_md (d_uses_md),
        .busy      (busy),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Issue while busy would be silently dropped; the bench must never do it.
    always @(posedge clk) begin
        if (!reset && start && !cancel && busy)
            go_in_run++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, then count cycles with busy high (bounded).
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int cyc);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int cyc;
        int st;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy",  busy,  0);
        chk("rst_stall", stall, 0);
        chk("rst_hi",    hi,    0);
        chk("rst_lo",    lo,    0);

        run_op(MDU_MULT, 32'hFFFF_FFFF, 32'd2, cyc);
        chk("mult_cyc", cyc, 5);
        chk("mult_hi",  hi, 32'hFFFF_FFFF);
        chk("mult_lo",  lo, 32'hFFFF_FFFE);

        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, cyc);
        chk("multu_cyc", cyc, 5);
        chk("multu_hi",  hi, 32'h0000_0001);
        chk("multu_lo",  lo, 32'hFFFF_FFFE);

        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
        chk("div_cyc", cyc, 10);
        chk("div_hi",  hi, 32'hFFFF_FFFF);
        chk("div_lo",  lo, 32'hFFFF_FFFD);

        run_op(MDU_DIVU, 32'd7, 32'd0, cyc);
        chk("divz_cyc", cyc, 10);
        chk("divz_hi",  hi, 32'hFFFF_FFFF);
        chk("divz_lo",  lo, 32'hFFFF_FFFD);

        // stall window for a MULT with a D-stage MDU user held
        d_uses_md = 1'b1;
        @(negedge clk);
        start = 1'b1; op = MDU_MULT; a = 32'd2; b = 32'd3;
        #1 chk("stall_issue", stall, 1);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; st = 0;
        while (busy && cyc < 40) begin
            cyc++;
            if (stall) st++;
            @(posedge clk); #1;
        end
        chk("stall_cycles", st, 5);
        chk("stall_drop",   stall, 0);
        chk("stall_mul_lo", lo, 32'd6);
        chk("stall_mul_hi", hi, 32'd0);

        // MTHI never stalls, updates at the issue edge
        @(negedge clk);
        start = 1'b1; op = MDU_MTHI; a = 32'h1234;
        #1 chk("mthi_stall", stall, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("mthi_hi",   hi, 32'h1234);
        chk("mthi_busy", busy, 0);
        d_uses_md = 1'b0;

        // cancelled DIV leaves everything untouched
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = MDU_DIV; a = 32'd9; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        chk("cancel_busy", busy, 0);
        chk("cancel_hi",   hi, 32'h1234);
        chk("cancel_lo",   lo, 32'd6);

        @(negedge clk);
        start = 1'b1; op = MDU_MTLO; a = 32'h55;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h55);

        // asynchronous reset in the middle of a DIV
        @(negedge clk);
        start = 1'b1; op = MDU_DIV; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        chk("div_nostall", stall, 0);
        chk("div_busy",    busy, 1);
        repeat (3) @(posedge clk);
        #3;
        chk("mid_hi", hi, 32'h1234);
        reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_hi",   hi, 0);
        chk("arst_lo",   lo, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op(MDU_MULT, 32'd3, 32'd5, cyc);
        chk("post_rst_cyc", cyc, 5);
        chk("post_rst_hi",  hi, 0);
        chk("post_rst_lo",  lo, 32'd15);

        // MADD / MSUB from {hi,lo} = {0,5}
        run_op(MDU_MTHI, 32'd0, 32'd0, cyc);
        run_op(MDU_MTLO, 32'd5, 32'd0, cyc);
        run_op(MDU_MADD, 32'd3, 32'd4, cyc);
`ifdef MDU_MADD_EN
        chk("madd_cyc", cyc, 5);
        chk("madd_hi",  hi, 0);
        chk("madd_lo",  lo, 32'd17);
`else
        chk("madd_cyc", cyc, 0);
        chk("madd_hi",  hi, 0);
        chk("madd_lo",  lo, 32'd5);
`endif
        run_op(MDU_MTLO, 32'd5, 32'd0, cyc);
        run_op(MDU_MSUB, 32'd3, 32'd4, cyc);
`ifdef MDU_MADD_EN
        chk("msub_cyc", cyc, 5);
        chk("msub_hi",  hi, 32'hFFFF_FFFF);
        chk("msub_lo",  lo, 32'hFFFF_FFF9);
`else
        chk("msub_cyc", cyc, 0);
        chk("msub_hi",  hi, 0);
        chk("msub_lo",  lo, 32'd5);
`endif

        chk("go_in_run", go_in_run, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
